uart_rx_fifo: RTL and testbench

Receive buffer between the `uart` core and the UART Wishbone slave. It captures each byte the core reports as received, along with that byte's framing-error status, into a first-word-fall-through FIFO. The bus side can then read bytes at its own pace instead of racing the line rate. It also provides occupancy, a sticky overrun flag and a threshold interrupt for the CPU.

---
 rtl/uart_rx_fifo_if.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the receive-side and bus-side signals of the UART
// receive buffer.
//
// Signal semantics:
//   rx_valid is a one-cycle pulse. rx_byte and rx_error are qualified by it.
//   There is no back-pressure toward the core. A byte that arrives while the
//   FIFO is full is dropped and flagged through overrun.
//   pop, flush and clear_ovr are one-cycle strobes from the bus side.
//   rd_data and rd_err are the FIFO head (first-word-fall-through). They are
//   meaningful only while empty is 0.
//
// Modports:
//   master : the side that drives the core and the bus strobes (testbench or glue)
//   slave  : the FIFO itself
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  rx_error;
  logic                  pop;
  logic                  flush;
  logic                  clear_ovr;
  logic [7:0]            rd_data;
  logic                  rd_err;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic [7:0]            err_cnt;
  logic                  irq;

  modport master (
    output rx_valid, rx_byte, rx_error, pop, flush, clear_ovr,
    input  rd_data, rd_err, empty, full, count, overrun, err_cnt, irq
  );

  modport slave (
    input  rx_valid, rx_byte, rx_error, pop, flush, clear_ovr,
    output rd_data, rd_err, empty, full, count, overrun, err_cnt, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer between the UART core
// and its bus slave. Each received byte is stored together with its
// framing-error bit. The block also provides occupancy, a sticky overrun
// flag, a saturating dropped-error counter and a registered threshold
// interrupt.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : uart_rx_fifo_if.slave
//          in : rx_valid/rx_byte/rx_error, pop, flush, clear_ovr
//          out: rd_data/rd_err, empty, full, count, overrun, err_cnt, irq
//
// Parameters:
//   DEPTH_LOG2 : depth is 2**DEPTH_LOG2 entries (1..8)
//   THRESHOLD  : irq asserts when count >= THRESHOLD
//   DROP_ERR   : 1 = error bytes are discarded and counted;
//                0 = error bytes are stored with their error bit
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESHOLD  = 8,
  parameter int DROP_ERR   = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam bit DROP  = (DROP_ERR != 0);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t THRESH_C = cnt_t'(THRESHOLD);

  logic [8:0] mem [DEPTH];
  ptr_t       wp;
  ptr_t       rp;
  cnt_t       count_q;
  cnt_t       count_nxt;
  logic       overrun_q;
  logic [7:0] err_cnt_q;
  logic       irq_q;

  logic       push_req;
  logic       drop_evt;
  logic       pop_ok;
  logic       is_full;
  logic       do_push;
  logic       ovr_evt;
  logic       wr_err;

  // Error bytes never reach storage when DROP is set, so the stored
  // error bit can only be 0 in that configuration.
  assign push_req = bus.rx_valid && !(DROP && bus.rx_error);
  assign drop_evt = DROP && bus.rx_valid && bus.rx_error;
  assign wr_err   = DROP ? 1'b0 : bus.rx_error;

  assign is_full  = (count_q == DEPTH_C);
  assign pop_ok   = bus.pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push_req && (!is_full || pop_ok);
  // A flush discards the incoming byte on purpose. That is not an overrun.
  assign ovr_evt  = push_req && is_full && !pop_ok && !bus.flush;

  always_comb begin
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else if (do_push && !pop_ok) begin
      count_nxt = count_q + cnt_t'(1);
    end else if (!do_push && pop_ok) begin
      count_nxt = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (bus.flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (do_push) wp <= wp + ptr_t'(1);
        if (pop_ok)  rp <= rp + ptr_t'(1);
      end
      count_q <= count_nxt;
      // Registered from the next count so irq moves in the same cycle as count.
      irq_q   <= (count_nxt >= THRESH_C);
      // A new overrun takes priority over a coincident clear.
      if (ovr_evt) begin
        overrun_q <= 1'b1;
      end else if (bus.clear_ovr) begin
        overrun_q <= 1'b0;
      end
      if (drop_evt && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Storage is not reset. The head is don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !bus.flush) begin
      mem[wp] <= {wr_err, bus.rx_byte};
    end
  end

  assign bus.rd_data = mem[rp][7:0];
  assign bus.rd_err  = DROP ? 1'b0 : mem[rp][8];
  assign bus.empty   = (count_q == '0);
  assign bus.full    = is_full;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if #(.DEPTH_LOG2(4)) b0 ();
  uart_rx_fifo_if #(.DEPTH_LOG2(4)) b1 ();

  uart_rx_fifo #(.DEPTH_LOG2(4), .THRESHOLD(8), .DROP_ERR(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  uart_rx_fifo #(.DEPTH_LOG2(4), .THRESHOLD(8), .DROP_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one cycle of stimulus to dut0; sample #1 after the edge
  task automatic cyc(input logic v, input logic [7:0] b, input logic e,
                     input logic p, input logic f, input logic c);
    b0.rx_valid = v; b0.rx_byte = b; b0.rx_error = e;
    b0.pop = p; b0.flush = f; b0.clear_ovr = c;
    @(posedge clk); #1;
    b0.rx_valid = 1'b0; b0.rx_error = 1'b0; b0.pop = 1'b0;
    b0.flush = 1'b0; b0.clear_ovr = 1'b0;
  endtask

  task automatic cyc1(input logic v, input logic [7:0] b, input logic e, input logic p);
    b1.rx_valid = v; b1.rx_byte = b; b1.rx_error = e; b1.pop = p;
    @(posedge clk); #1;
    b1.rx_valid = 1'b0; b1.rx_error = 1'b0; b1.pop = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", b0.empty); end
    n_cmp++; if (b0.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", b0.full); end
    n_cmp++; if (b0.count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", b0.count); end
    n_cmp++; if (b0.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b exp 0", b0.overrun); end
    n_cmp++; if (b0.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b exp 0", b0.irq); end
    n_cmp++; if (b1.err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d exp 0", b1.err_cnt); end
  endtask

  task automatic test_basic;
    cyc(1, 8'h41, 0, 0, 0, 0);
    n_cmp++; if (b0.count !== 5'd1) begin n_err++; $display("FAIL basic_count1: got %0d exp 1", b0.count); end
    n_cmp++; if (b0.empty !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b exp 0", b0.empty); end
    n_cmp++; if (b0.rd_data !== 8'h41) begin n_err++; $display("FAIL basic_fwft: got %h exp 41", b0.rd_data); end
    cyc(1, 8'h42, 0, 0, 0, 0);
    n_cmp++; if (b0.count !== 5'd2) begin n_err++; $display("FAIL basic_count2: got %0d exp 2", b0.count); end
    cyc(1, 8'h43, 0, 0, 0, 0);
    n_cmp++; if (b0.count !== 5'd3) begin n_err++; $display("FAIL basic_count3: got %0d exp 3", b0.count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (b0.rd_data !== 8'(8'h41 + i)) begin n_err++; $display("FAIL basic_pop%0d: got %h exp %h", i, b0.rd_data, 8'(8'h41 + i)); end
      cyc(0, 8'h00, 0, 1, 0, 0);
    end
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_end: got %b exp 1", b0.empty); end
  endtask

  task automatic test_full_overrun;
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    n_cmp++; if (b0.full !== 1'b1) begin n_err++; $display("FAIL ovr_full: got %b exp 1", b0.full); end
    n_cmp++; if (b0.count !== 5'd16) begin n_err++; $display("FAIL ovr_count: got %0d exp 16", b0.count); end
    n_cmp++; if (b0.irq !== 1'b1) begin n_err++; $display("FAIL ovr_irq: got %b exp 1", b0.irq); end
    cyc(1, 8'hAA, 0, 0, 0, 0);
    n_cmp++; if (b0.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b exp 1", b0.overrun); end
    n_cmp++; if (b0.count !== 5'd16) begin n_err++; $display("FAIL ovr_count_hold: got %0d exp 16", b0.count); end
    cyc(1, 8'hBB, 0, 0, 0, 1);
    n_cmp++; if (b0.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins: got %b exp 1", b0.overrun); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (b0.rd_data !== 8'(i)) begin n_err++; $display("FAIL ovr_pop%0d: got %h exp %h", i, b0.rd_data, 8'(i)); end
      cyc(0, 8'h00, 0, 1, 0, 0);
    end
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL ovr_drained: got %b exp 1", b0.empty); end
    n_cmp++; if (b0.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b exp 1", b0.overrun); end
    cyc(0, 8'h00, 0, 0, 0, 1);
    n_cmp++; if (b0.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b exp 0", b0.overrun); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0, 0);
    n_cmp++; if (b0.rd_data !== 8'h00) begin n_err++; $display("FAIL fpp_head: got %h exp 00", b0.rd_data); end
    cyc(1, 8'h55, 0, 1, 0, 0);
    n_cmp++; if (b0.count !== 5'd16) begin n_err++; $display("FAIL fpp_count: got %0d exp 16", b0.count); end
    n_cmp++; if (b0.overrun !== 1'b0) begin n_err++; $display("FAIL fpp_overrun: got %b exp 0", b0.overrun); end
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if (b0.rd_data !== ((k < 16) ? 8'(k) : 8'h55)) begin n_err++; $display("FAIL fpp_read%0d: got %h exp %h", k, b0.rd_data, ((k < 16) ? 8'(k) : 8'h55)); end
      cyc(0, 8'h00, 0, 1, 0, 0);
    end
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL fpp_empty: got %b exp 1", b0.empty); end
  endtask

  // scoreboard: exp_q holds bytes in write order; at most 2 outstanding
  task automatic test_wrap;
    logic [4:0] cnt_before;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 2) begin
        cnt_before = b0.count;
        n_cmp++; if (b0.rd_data !== exp_q[0]) begin n_err++; $display("FAIL wrap_read%0d: got %h exp %h", i, b0.rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(8'(i));
        cyc(1, 8'(i), 0, 1, 0, 0);
        n_cmp++; if (b0.count !== cnt_before) begin n_err++; $display("FAIL wrap_count%0d: got %0d exp %0d", i, b0.count, cnt_before); end
      end else begin
        exp_q.push_back(8'(i));
        cyc(1, 8'(i), 0, 0, 0, 0);
      end
    end
    while (exp_q.size() > 0) begin
      n_cmp++; if (b0.rd_data !== exp_q[0]) begin n_err++; $display("FAIL wrap_drain: got %h exp %h", b0.rd_data, exp_q[0]); end
      void'(exp_q.pop_front());
      cyc(0, 8'h00, 0, 1, 0, 0);
    end
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b exp 1", b0.empty); end
  endtask

  task automatic test_err_store;
    cyc(1, 8'h7E, 1, 0, 0, 0);
    n_cmp++; if (b0.rd_err !== 1'b1) begin n_err++; $display("FAIL errst_rd_err: got %b exp 1", b0.rd_err); end
    n_cmp++; if (b0.rd_data !== 8'h7E) begin n_err++; $display("FAIL errst_rd_data: got %h exp 7e", b0.rd_data); end
    cyc(0, 8'h00, 0, 1, 0, 0);
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL errst_empty: got %b exp 1", b0.empty); end
  endtask

  task automatic test_drop_err;
    for (int i = 0; i < 300; i++) begin
      cyc1(1, 8'h7E, 1, 0);
      if (i == 9) begin
        n_cmp++; if (b1.err_cnt !== 8'd10) begin n_err++; $display("FAIL drop_cnt10: got %0d exp 10", b1.err_cnt); end
      end
    end
    n_cmp++; if (b1.err_cnt !== 8'd255) begin n_err++; $display("FAIL drop_sat: got %0d exp 255", b1.err_cnt); end
    n_cmp++; if (b1.empty !== 1'b1) begin n_err++; $display("FAIL drop_empty: got %b exp 1", b1.empty); end
    cyc1(1, 8'h33, 0, 0);
    n_cmp++; if (b1.rd_data !== 8'h33) begin n_err++; $display("FAIL drop_good_data: got %h exp 33", b1.rd_data); end
    n_cmp++; if (b1.rd_err !== 1'b0) begin n_err++; $display("FAIL drop_good_err: got %b exp 0", b1.rd_err); end
    n_cmp++; if (b1.count !== 5'd1) begin n_err++; $display("FAIL drop_good_count: got %0d exp 1", b1.count); end
    cyc1(0, 8'h00, 0, 1);
  endtask

  task automatic test_threshold;
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0, 0);
    n_cmp++; if (b0.irq !== 1'b0) begin n_err++; $display("FAIL thr_irq7: got %b exp 0", b0.irq); end
    cyc(1, 8'h17, 0, 0, 0, 0);
    n_cmp++; if (b0.irq !== 1'b1) begin n_err++; $display("FAIL thr_irq8: got %b exp 1", b0.irq); end
    cyc(0, 8'h00, 0, 1, 0, 0);
    n_cmp++; if (b0.irq !== 1'b0) begin n_err++; $display("FAIL thr_irq_pop: got %b exp 0", b0.irq); end
    n_cmp++; if (b0.count !== 5'd7) begin n_err++; $display("FAIL thr_count7: got %0d exp 7", b0.count); end
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0, 0);
    n_cmp++; if (b0.full !== 1'b1) begin n_err++; $display("FAIL thr_full: got %b exp 1", b0.full); end
    cyc(1, 8'hEE, 0, 1, 1, 0);
    n_cmp++; if (b0.count !== 5'd0) begin n_err++; $display("FAIL flush_count: got %0d exp 0", b0.count); end
    n_cmp++; if (b0.overrun !== 1'b0) begin n_err++; $display("FAIL flush_overrun: got %b exp 0", b0.overrun); end
    n_cmp++; if (b0.irq !== 1'b0) begin n_err++; $display("FAIL flush_irq: got %b exp 0", b0.irq); end
  endtask

  task automatic test_pop_empty;
    cyc(0, 8'h00, 0, 1, 0, 0);
    n_cmp++; if (b0.count !== 5'd0) begin n_err++; $display("FAIL popempty_count: got %0d exp 0", b0.count); end
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL popempty_empty: got %b exp 1", b0.empty); end
    cyc(1, 8'h99, 0, 1, 0, 0);
    n_cmp++; if (b0.count !== 5'd1) begin n_err++; $display("FAIL pushpop_empty_count: got %0d exp 1", b0.count); end
    n_cmp++; if (b0.rd_data !== 8'h99) begin n_err++; $display("FAIL pushpop_empty_data: got %h exp 99", b0.rd_data); end
    cyc(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_mid_reset;
    cyc(1, 8'h01, 0, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 8'h11, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (b0.count !== 5'd0) begin n_err++; $display("FAIL midrst_count: got %0d exp 0", b0.count); end
    n_cmp++; if (b0.empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %b exp 1", b0.empty); end
    n_cmp++; if (b1.err_cnt !== 8'd0) begin n_err++; $display("FAIL midrst_err_cnt: got %0d exp 0", b1.err_cnt); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    b0.rx_valid = 0; b0.rx_byte = 0; b0.rx_error = 0; b0.pop = 0; b0.flush = 0; b0.clear_ovr = 0;
    b1.rx_valid = 0; b1.rx_byte = 0; b1.rx_error = 0; b1.pop = 0; b1.flush = 0; b1.clear_ovr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_full_overrun;
    test_full_push_pop;
    test_wrap;
    test_err_store;
    test_drop_err;
    test_threshold;
    test_pop_empty;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
